mdu_ex: RTL and testbench

//   EX-stage multiply/divide unit: owns HI/LO and runs mult/multu/div/divu with fixed multi-cycle

---
 rtl/mdu_ex_pkg.sv | 24 ++
 rtl/mdu_ex.sv | 131 +++++++++++++
 tb/tb_mdu_ex.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_ex_pkg.sv
// Shared MDU opcode encodings and helpers, used by the controller and the EX-stage MDU.
package mdu_ex_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MTHI  = 4'd5,
    MDU_MTLO  = 4'd6,
    MDU_MFHI  = 4'd7,
    MDU_MFLO  = 4'd8
  } mdu_op_e;

  function automatic logic is_arith_op(input mdu_op_e op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic is_div_op(input mdu_op_e op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_ex.sv
// EX-stage multiply/divide unit: owns HI/LO, runs mult/div with a fixed latency,
// and serves mthi/mtlo/mfhi/mflo.
module mdu_ex
  import mdu_ex_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        ActivateCP0,
  input  logic        Start,
  input  logic [3:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI_Out,
  output logic [31:0] LO_Out,
  output logic [31:0] MDU_Out
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  mdu_op_e       op;
  logic [CW-1:0] count;
  logic [31:0]   hi;
  logic [31:0]   lo;
  logic [31:0]   pend_hi;
  logic [31:0]   pend_lo;
  logic          pend_write;
  logic          issue;

  logic [63:0]   prod_s;
  logic [63:0]   prod_u;
  logic [31:0]   divisor_u;
  logic [31:0]   a_mag;
  logic [31:0]   b_mag;
  logic [31:0]   q_mag;
  logic [31:0]   r_mag;
  logic [31:0]   q_s;
  logic [31:0]   r_s;
  logic [31:0]   res_hi;
  logic [31:0]   res_lo;

  assign op     = mdu_op_e'(MDUOp);
  assign Busy   = (count != '0);
  assign HI_Out = hi;
  assign LO_Out = lo;
  assign issue  = Start && !Busy && !ActivateCP0 && is_arith_op(op);

  // Signed divide works on magnitudes so INT_MIN / -1 needs no special case
  // and never reaches a native signed-overflow divide.
  always_comb begin
    prod_s    = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    prod_u    = {32'd0, A} * {32'd0, B};
    divisor_u = (B == 32'd0) ? 32'd1 : B;
    a_mag     = A[31] ? (32'd0 - A) : A;
    b_mag     = B[31] ? (32'd0 - B) : divisor_u;
    q_mag     = a_mag / b_mag;
    r_mag     = a_mag % b_mag;
    q_s       = (A[31] ^ B[31]) ? (32'd0 - q_mag) : q_mag;
    r_s       = A[31] ? (32'd0 - r_mag) : r_mag;
  end

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    unique case (op)
      MDU_MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      MDU_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      MDU_DIV: begin
        res_hi = r_s;
        res_lo = q_s;
      end
      MDU_DIVU: begin
        res_hi = A % divisor_u;
        res_lo = A / divisor_u;
      end
      default: begin
        res_hi = 32'd0;
        res_lo = 32'd0;
      end
    endcase
  end

  always_comb begin
    MDU_Out = 32'd0;
    if (op == MDU_MFHI) begin
      MDU_Out = hi;
    end else if (op == MDU_MFLO) begin
      MDU_Out = lo;
    end
  end

  // A divide by zero still runs its full latency but leaves pend_write clear.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      hi         <= 32'd0;
      lo         <= 32'd0;
      pend_hi    <= 32'd0;
      pend_lo    <= 32'd0;
      pend_write <= 1'b0;
      count      <= '0;
    end else if (Busy) begin
      count <= count - CW'(1);
      if ((count == CW'(1)) && pend_write) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end
    end else if (issue) begin
      pend_hi    <= res_hi;
      pend_lo    <= res_lo;
      pend_write <= !(is_div_op(op) && (B == 32'd0));
      count      <= is_div_op(op) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
    end else if (!ActivateCP0) begin
      if (op == MDU_MTHI) begin
        hi <= A;
      end else if (op == MDU_MTLO) begin
        lo <= A;
      end
    end
  end

endmodule

// File: tb/tb_mdu_ex.sv
// Self-checking bench for mdu_ex: directed cases plus random traffic against a
// cycle-level reference model built from plain 64-bit arithmetic.
module tb_mdu_ex;
  import mdu_ex_pkg::*;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        Clk;
  logic        Rst;
  logic        ActivateCP0;
  logic        Start;
  logic [3:0]  MDUOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] HI_Out;
  logic [31:0] LO_Out;
  logic [31:0] MDU_Out;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic [31:0] m_pend_hi;
  logic [31:0] m_pend_lo;
  logic        m_pend_valid;
  int          m_rem;

  mdu_ex #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .Clk(Clk),
    .Rst(Rst),
    .ActivateCP0(ActivateCP0),
    .Start(Start),
    .MDUOp(MDUOp),
    .A(A),
    .B(B),
    .Busy(Busy),
    .HI_Out(HI_Out),
    .LO_Out(LO_Out),
    .MDU_Out(MDU_Out)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: what the unit should do at one clock edge, from the ISA rules.
  task automatic modelEdge(input logic rst, input logic cp0, input logic start,
                           input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa;
    longint          sb;
    longint          sp;
    longint unsigned up;
    if (rst) begin
      m_hi = 0; m_lo = 0; m_pend_hi = 0; m_pend_lo = 0; m_pend_valid = 0; m_rem = 0;
    end else if (m_rem > 0) begin
      m_rem = m_rem - 1;
      if (m_rem == 0 && m_pend_valid) begin
        m_hi = m_pend_hi;
        m_lo = m_pend_lo;
      end
    end else if (start && !cp0 && (op >= 4'd1) && (op <= 4'd4)) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      m_pend_valid = 1;
      case (op)
        4'd1: begin
          sp = sa * sb;
          m_pend_hi = sp[63:32]; m_pend_lo = sp[31:0];
          m_rem = MULT_N;
        end
        4'd2: begin
          up = longint'(a) * longint'(b);
          m_pend_hi = up[63:32]; m_pend_lo = up[31:0];
          m_rem = MULT_N;
        end
        4'd3: begin
          if (b == 0) m_pend_valid = 0;
          else begin
            sp = sa / sb;
            m_pend_lo = sp[31:0];
            sp = sa % sb;
            m_pend_hi = sp[31:0];
          end
          m_rem = DIV_N;
        end
        default: begin
          if (b == 0) m_pend_valid = 0;
          else begin
            m_pend_lo = a / b;
            m_pend_hi = a % b;
          end
          m_rem = DIV_N;
        end
      endcase
    end else if (!cp0 && op == 4'd5) begin
      m_hi = a;
    end else if (!cp0 && op == 4'd6) begin
      m_lo = a;
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [31:0] exp_out;
    exp_out = (MDUOp == 4'd7) ? m_hi : (MDUOp == 4'd8) ? m_lo : 32'd0;
    checkVal({tag, "_busy"}, {31'd0, Busy}, (m_rem != 0) ? 32'd1 : 32'd0);
    checkVal({tag, "_hi"}, HI_Out, m_hi);
    checkVal({tag, "_lo"}, LO_Out, m_lo);
    checkVal({tag, "_out"}, MDU_Out, exp_out);
  endtask

  task automatic applyStimulus(input string tag, input logic rst, input logic cp0, input logic start,
                               input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge Clk);
    Rst = rst; ActivateCP0 = cp0; Start = start; MDUOp = op; A = a; B = b;
    @(posedge Clk);
    modelEdge(rst, cp0, start, op, a, b);
    #1;
    checkOutput(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) applyStimulus(tag, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
  endtask

  initial begin
    logic        r_rst;
    logic        r_cp0;
    logic        r_start;
    logic [3:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    m_hi = 0; m_lo = 0; m_pend_hi = 0; m_pend_lo = 0; m_pend_valid = 0; m_rem = 0;
    Rst = 1'b1; ActivateCP0 = 1'b0; Start = 1'b0; MDUOp = 4'd0; A = 32'd0; B = 32'd0;

    applyStimulus("rst0", 1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    applyStimulus("rst1", 1'b1, 1'b1, 1'b1, 4'd1, 32'h5, 32'h6);
    checkVal("reset_busy", {31'd0, Busy}, 32'd0);
    checkVal("reset_hi", HI_Out, 32'd0);

    applyStimulus("mthi", 1'b0, 1'b0, 1'b0, 4'd5, 32'h1234, 32'd0);
    applyStimulus("mtlo", 1'b0, 1'b0, 1'b0, 4'd6, 32'h5678, 32'd0);
    applyStimulus("mfhi", 1'b0, 1'b0, 1'b0, 4'd7, 32'd0, 32'd0);
    checkVal("t1_mfhi", MDU_Out, 32'h1234);
    checkVal("t1_lo", LO_Out, 32'h5678);

    applyStimulus("mult", 1'b0, 1'b0, 1'b1, 4'd1, 32'hFFFFFFFE, 32'd3);
    checkVal("t2_busy_start", {31'd0, Busy}, 32'd1);
    idle("mult_wait", MULT_N - 1);
    checkVal("t2_busy_last", {31'd0, Busy}, 32'd1);
    idle("mult_done", 1);
    checkVal("t2_mult_hi", HI_Out, 32'hFFFFFFFF);
    checkVal("t2_mult_lo", LO_Out, 32'hFFFFFFFA);
    applyStimulus("multu", 1'b0, 1'b0, 1'b1, 4'd2, 32'hFFFFFFFE, 32'd3);
    idle("multu_wait", MULT_N);
    checkVal("t2_multu_hi", HI_Out, 32'h2);
    checkVal("t2_multu_lo", LO_Out, 32'hFFFFFFFA);

    applyStimulus("div", 1'b0, 1'b0, 1'b1, 4'd3, 32'hFFFFFFF9, 32'd2);
    idle("div_wait", DIV_N - 1);
    checkVal("t3_div_busy_last", {31'd0, Busy}, 32'd1);
    idle("div_done", 1);
    checkVal("t3_div_lo", LO_Out, 32'hFFFFFFFD);
    checkVal("t3_div_hi", HI_Out, 32'hFFFFFFFF);
    applyStimulus("divu", 1'b0, 1'b0, 1'b1, 4'd4, 32'd7, 32'd2);
    idle("divu_wait", DIV_N);
    checkVal("t3_divu_lo", LO_Out, 32'd3);
    checkVal("t3_divu_hi", HI_Out, 32'd1);

    applyStimulus("mthi_aa", 1'b0, 1'b0, 1'b0, 4'd5, 32'hAA, 32'd0);
    applyStimulus("mtlo_bb", 1'b0, 1'b0, 1'b0, 4'd6, 32'hBB, 32'd0);
    applyStimulus("div0", 1'b0, 1'b0, 1'b1, 4'd3, 32'h1234, 32'd0);
    idle("div0_wait", DIV_N - 1);
    checkVal("t4_div0_busy_last", {31'd0, Busy}, 32'd1);
    idle("div0_done", 1);
    checkVal("t4_div0_hi", HI_Out, 32'hAA);
    checkVal("t4_div0_lo", LO_Out, 32'hBB);
    applyStimulus("divmin", 1'b0, 1'b0, 1'b1, 4'd3, 32'h80000000, 32'hFFFFFFFF);
    idle("divmin_wait", DIV_N);
    checkVal("t4_divmin_lo", LO_Out, 32'h80000000);
    checkVal("t4_divmin_hi", HI_Out, 32'd0);

    applyStimulus("cp0_mult", 1'b0, 1'b1, 1'b1, 4'd1, 32'd9, 32'd9);
    checkVal("t5_cp0_busy", {31'd0, Busy}, 32'd0);
    checkVal("t5_cp0_lo", LO_Out, 32'h80000000);
    applyStimulus("div_cp0", 1'b0, 1'b0, 1'b1, 4'd3, 32'd100, 32'd7);
    idle("div_cp0_a", 3);
    applyStimulus("cp0_mid", 1'b0, 1'b1, 1'b0, 4'd0, 32'd0, 32'd0);
    idle("div_cp0_b", DIV_N - 4);
    checkVal("t5_mid_lo", LO_Out, 32'd14);
    checkVal("t5_mid_hi", HI_Out, 32'd2);
    applyStimulus("cp0_mtlo", 1'b0, 1'b1, 1'b0, 4'd6, 32'hDEAD, 32'd0);
    checkVal("t5_mtlo_lo", LO_Out, 32'd14);

    applyStimulus("div_rst", 1'b0, 1'b0, 1'b1, 4'd3, 32'd50, 32'd5);
    idle("div_rst_wait", 2);
    applyStimulus("rst_mid", 1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    checkVal("t6_rst_busy", {31'd0, Busy}, 32'd0);
    checkVal("t6_rst_lo", LO_Out, 32'd0);
    idle("rst_after", DIV_N);
    checkVal("t6_nolate_lo", LO_Out, 32'd0);
    checkVal("t6_nolate_hi", HI_Out, 32'd0);
    applyStimulus("mult_b", 1'b0, 1'b0, 1'b1, 4'd1, 32'd3, 32'd4);
    applyStimulus("start_busy", 1'b0, 1'b0, 1'b1, 4'd4, 32'd9, 32'd3);
    applyStimulus("mthi_busy", 1'b0, 1'b0, 1'b0, 4'd5, 32'h77, 32'd0);
    idle("mult_b_wait", MULT_N - 2);
    checkVal("t6_ign_busy", {31'd0, Busy}, 32'd0);
    checkVal("t6_ign_lo", LO_Out, 32'd12);
    idle("ign_after", DIV_N);
    checkVal("t6_ign_after_lo", LO_Out, 32'd12);
    checkVal("t6_ign_after_hi", HI_Out, 32'd0);

    for (int i = 0; i < 600; i++) begin
      r_rst   = ($urandom_range(0, 99) == 0);
      r_cp0   = ($urandom_range(0, 9) == 0);
      r_start = ($urandom_range(0, 2) == 0);
      r_op    = r_start ? 4'($urandom_range(1, 4)) : 4'($urandom_range(0, 8));
      r_a     = $urandom();
      r_b     = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom();
      if ($urandom_range(0, 9) == 0) r_a = 32'h80000000;
      if ($urandom_range(0, 9) == 0) r_b = 32'hFFFFFFFF;
      if ($urandom_range(0, 3) == 0) r_b = 32'($urandom_range(1, 20));
      applyStimulus("rand", r_rst, r_cp0, r_start, r_op, r_a, r_b);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
